// File: rtl/gpc1343_share_sched_if.sv
// Requester beats and the registered result slot of gpc1343_share_sched, as one bundle.
// The master side is the producer and consumer pair; the slave side is the scheduler.
interface gpc1343_share_sched_if #(
    parameter int ACC_W = 12
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_last;
    logic [5:0]       req_src0;
    logic [7:0]       req_src1;
    logic [5:0]       req_src2;
    logic [1:0]       req_src3;
    logic             out_valid;
    logic             out_ready;
    logic             out_id;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output req_valid, req_last, req_src0, req_src1, req_src2, req_src3, out_ready,
        input  req_ready, out_valid, out_id, out_sum, out_ovf
    );

    modport slave (
        input  req_valid, req_last, req_src0, req_src1, req_src2, req_src3, out_ready,
        output req_ready, out_valid, out_id, out_sum, out_ovf
    );
endinterface

// File: rtl/gpc1343_share_sched.sv
// Two requesters share one gpc1343_5 compressor; the packet total is registered one cycle after the last beat.
// Only last beats wait on a full result slot; non-last beats are accepted regardless of out_ready.
module gpc1343_share_sched #(
    parameter int ACC_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    gpc1343_share_sched_if.slave  bus
);
    logic [ACC_W-1:0] acc_q [2];
    logic [ACC_W-1:0] acc_d [2];
    logic [1:0]       ovf_q, ovf_d;
    logic             ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic             out_id_q, out_id_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;

    logic             slot_free;
    logic [1:0]       elig, grant;
    logic             g, last_g;
    logic [2:0]       col0, col2;
    logic [3:0]       col1;
    logic             col3;
    logic [4:0]       dst;
    logic [ACC_W:0]   sum;
    logic             ovf_next;

    function automatic logic [4:0] gpc1343_5(input logic [2:0] c0, input logic [3:0] c1,
                                             input logic [2:0] c2, input logic c3);
        logic [4:0] s;
        s = {1'b0, c3, 3'd0};
        for (int k = 0; k < 3; k++) s = s + {4'd0, c0[k]} + {2'd0, c2[k], 2'd0};
        for (int k = 0; k < 4; k++) s = s + {3'd0, c1[k], 1'b0};
        return s;
    endfunction

    always_comb begin
        slot_free = !out_valid_q || bus.out_ready;
        elig      = bus.req_valid & (~bus.req_last | {2{slot_free}}) & {2{!rst}};
        grant     = elig;
        if (&elig) grant = ptr_q ? 2'b10 : 2'b01;
        g      = grant[1];
        last_g = g ? bus.req_last[1] : bus.req_last[0];

        // Idle compressor inputs are forced to zero so nothing undefined reaches the adder.
        col0 = '0;
        col1 = '0;
        col2 = '0;
        col3 = 1'b0;
        if (grant[0]) begin
            col0 = bus.req_src0[2:0];
            col1 = bus.req_src1[3:0];
            col2 = bus.req_src2[2:0];
            col3 = bus.req_src3[0];
        end else if (grant[1]) begin
            col0 = bus.req_src0[5:3];
            col1 = bus.req_src1[7:4];
            col2 = bus.req_src2[5:3];
            col3 = bus.req_src3[1];
        end
        dst      = gpc1343_5(col0, col1, col2, col3);
        sum      = {1'b0, acc_q[g]} + {{(ACC_W-4){1'b0}}, dst};
        ovf_next = ovf_q[g] | sum[ACC_W];

        acc_d       = acc_q;
        ovf_d       = ovf_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        if (|grant) begin
            ptr_d = !g;
            if (last_g) begin
                out_valid_d = 1'b1;
                out_id_d    = g;
                out_sum_d   = sum[ACC_W-1:0];
                out_ovf_d   = ovf_next;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
                acc_d[i] = last_g ? '0 : sum[ACC_W-1:0];
                ovf_d[i] = last_g ? 1'b0 : ovf_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q[0]    <= '0;
            acc_q[1]    <= '0;
            ovf_q       <= '0;
            ptr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q[0]    <= acc_d[0];
            acc_q[1]    <= acc_d[1];
            ovf_q       <= ovf_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_gpc1343_share_sched.sv
// Directed bench for gpc1343_share_sched: a 12-bit instance for most scenarios, a 5-bit one for wrap.
module tb_gpc1343_share_sched;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gpc1343_share_sched_if #(.ACC_W(12)) ifa ();
    gpc1343_share_sched_if #(.ACC_W(5))  ifb ();

    gpc1343_share_sched #(.ACC_W(12)) u_dut  (.clk(clk), .rst(rst), .bus(ifa));
    gpc1343_share_sched #(.ACC_W(5))  u_dut5 (.clk(clk), .rst(rst), .bus(ifb));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.req_valid = '0; ifa.req_last = '0; ifa.req_src0 = '0; ifa.req_src1 = '0;
        ifa.req_src2  = '0; ifa.req_src3 = '0; ifa.out_ready = 1'b1;
        ifb.req_valid = '0; ifb.req_last = '0; ifb.req_src0 = '0; ifb.req_src1 = '0;
        ifb.req_src2  = '0; ifb.req_src3 = '0; ifb.out_ready = 1'b1;
    endtask

    task automatic set_a(input int r, input logic v, input logic l, input logic [2:0] s0,
                         input logic [3:0] s1, input logic [2:0] s2, input logic s3);
        ifa.req_valid[r]      = v;
        ifa.req_last[r]       = l;
        ifa.req_src0[3*r +: 3] = s0;
        ifa.req_src1[4*r +: 4] = s1;
        ifa.req_src2[3*r +: 3] = s2;
        ifa.req_src3[r]       = s3;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        ifa.req_valid = 2'b11;
        cyc();
        cyc();
        checks++; if (ifa.req_ready !== 2'b00) begin $display("FAIL reset_ready got=%b exp=00", ifa.req_ready); failures++; end
        checks++; if (ifa.out_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", ifa.out_valid); failures++; end
        checks++; if (ifa.out_id !== 1'b0) begin $display("FAIL reset_id got=%b exp=0", ifa.out_id); failures++; end
        checks++; if (ifa.out_sum !== 12'h000) begin $display("FAIL reset_sum got=%h exp=000", ifa.out_sum); failures++; end
        checks++; if (ifa.out_ovf !== 1'b0) begin $display("FAIL reset_ovf got=%b exp=0", ifa.out_ovf); failures++; end
        checks++; if (ifb.out_valid !== 1'b0) begin $display("FAIL reset_valid5 got=%b exp=0", ifb.out_valid); failures++; end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_basic();
        do_reset();
        set_a(0, 1'b1, 1'b0, 3'd2, 4'ha, 3'd3, 1'b0);
        @(negedge clk);
        checks++; if (ifa.req_ready !== 2'b01) begin $display("FAIL basic_rdy1 got=%b exp=01", ifa.req_ready); failures++; end
        cyc();
        set_a(0, 1'b1, 1'b1, 3'd0, 4'hd, 3'd1, 1'b1);
        @(negedge clk);
        checks++; if (ifa.out_valid !== 1'b0) begin $display("FAIL basic_early got=%b exp=0", ifa.out_valid); failures++; end
        checks++; if (ifa.req_ready !== 2'b01) begin $display("FAIL basic_rdy2 got=%b exp=01", ifa.req_ready); failures++; end
        cyc();
        set_a(0, 1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0);
        checks++; if (ifa.out_valid !== 1'b1) begin $display("FAIL basic_valid got=%b exp=1", ifa.out_valid); failures++; end
        checks++; if (ifa.out_id !== 1'b0) begin $display("FAIL basic_id got=%b exp=0", ifa.out_id); failures++; end
        checks++; if (ifa.out_sum !== 12'h01f) begin $display("FAIL basic_sum got=%h exp=01f", ifa.out_sum); failures++; end
        checks++; if (ifa.out_ovf !== 1'b0) begin $display("FAIL basic_ovf got=%b exp=0", ifa.out_ovf); failures++; end
        cyc();
        checks++; if (ifa.out_valid !== 1'b0) begin $display("FAIL basic_drain got=%b exp=0", ifa.out_valid); failures++; end
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        do_reset();
        set_a(0, 1'b1, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0);
        set_a(1, 1'b1, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++; if (ifa.req_ready !== exp) begin $display("FAIL fair_grant%0d got=%b exp=%b", i, ifa.req_ready, exp); failures++; end
            cyc();
        end
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        ifa.out_ready = 1'b0;
        set_a(0, 1'b1, 1'b1, 3'd7, 4'h0, 3'd1, 1'b0);
        cyc();
        set_a(0, 1'b1, 1'b0, 3'd2, 4'ha, 3'd3, 1'b0);
        set_a(1, 1'b1, 1'b1, 3'd1, 4'hf, 3'd0, 1'b1);
        @(negedge clk);
        checks++; if (ifa.req_ready !== 2'b01) begin $display("FAIL bp_rdy_nonlast got=%b exp=01", ifa.req_ready); failures++; end
        checks++; if (ifa.out_sum !== 12'h007) begin $display("FAIL bp_first_sum got=%h exp=007", ifa.out_sum); failures++; end
        cyc();
        set_a(0, 1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0);
        @(negedge clk);
        checks++; if (ifa.req_ready !== 2'b00) begin $display("FAIL bp_rdy_blocked got=%b exp=00", ifa.req_ready); failures++; end
        checks++; if (ifa.out_valid !== 1'b1) begin $display("FAIL bp_hold_valid got=%b exp=1", ifa.out_valid); failures++; end
        checks++; if (ifa.out_sum !== 12'h007) begin $display("FAIL bp_hold_sum got=%h exp=007", ifa.out_sum); failures++; end
        checks++; if (ifa.out_id !== 1'b0) begin $display("FAIL bp_hold_id got=%b exp=0", ifa.out_id); failures++; end
        cyc();
        ifa.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (ifa.req_ready !== 2'b10) begin $display("FAIL bp_rdy_release got=%b exp=10", ifa.req_ready); failures++; end
        cyc();
        set_a(1, 1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0);
        checks++; if (ifa.out_valid !== 1'b1) begin $display("FAIL bp_nogap got=%b exp=1", ifa.out_valid); failures++; end
        checks++; if (ifa.out_id !== 1'b1) begin $display("FAIL bp_id1 got=%b exp=1", ifa.out_id); failures++; end
        checks++; if (ifa.out_sum !== 12'h011) begin $display("FAIL bp_sum1 got=%h exp=011", ifa.out_sum); failures++; end
        set_a(0, 1'b1, 1'b1, 3'd0, 4'hd, 3'd1, 1'b1);
        cyc();
        set_a(0, 1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0);
        checks++; if (ifa.out_id !== 1'b0) begin $display("FAIL bp_id0 got=%b exp=0", ifa.out_id); failures++; end
        checks++; if (ifa.out_sum !== 12'h01f) begin $display("FAIL bp_sum0 got=%h exp=01f", ifa.out_sum); failures++; end
        cyc();
        checks++; if (ifa.out_valid !== 1'b0) begin $display("FAIL bp_drain got=%b exp=0", ifa.out_valid); failures++; end
    endtask

    task automatic test_overflow();
        do_reset();
        ifb.req_valid = 2'b01; ifb.req_last = 2'b00;
        ifb.req_src0 = 6'o07; ifb.req_src1 = 8'h0f; ifb.req_src2 = 6'o07; ifb.req_src3 = 2'b01;
        cyc();
        ifb.req_last = 2'b01;
        cyc();
        ifb.req_valid = 2'b00;
        checks++; if (ifb.out_valid !== 1'b1) begin $display("FAIL ovf_valid got=%b exp=1", ifb.out_valid); failures++; end
        checks++; if (ifb.out_sum !== 5'h1e) begin $display("FAIL ovf_sum got=%h exp=1e", ifb.out_sum); failures++; end
        checks++; if (ifb.out_ovf !== 1'b1) begin $display("FAIL ovf_flag got=%b exp=1", ifb.out_ovf); failures++; end
        ifb.req_valid = 2'b01; ifb.req_last = 2'b01;
        ifb.req_src0 = 6'o07; ifb.req_src1 = 8'h00; ifb.req_src2 = 6'o01; ifb.req_src3 = 2'b00;
        cyc();
        ifb.req_valid = 2'b00;
        checks++; if (ifb.out_sum !== 5'h07) begin $display("FAIL ovf_next_sum got=%h exp=07", ifb.out_sum); failures++; end
        checks++; if (ifb.out_ovf !== 1'b0) begin $display("FAIL ovf_next_flag got=%b exp=0", ifb.out_ovf); failures++; end
        idle();
    endtask

    task automatic test_interleave();
        do_reset();
        set_a(0, 1'b1, 1'b0, 3'd2, 4'ha, 3'd3, 1'b0);
        set_a(1, 1'b1, 1'b0, 3'd7, 4'hf, 3'd7, 1'b1);
        @(negedge clk);
        checks++; if (ifa.req_ready !== 2'b01) begin $display("FAIL il_rdy1 got=%b exp=01", ifa.req_ready); failures++; end
        cyc();
        set_a(0, 1'b1, 1'b1, 3'd0, 4'hd, 3'd1, 1'b1);
        @(negedge clk);
        checks++; if (ifa.req_ready !== 2'b10) begin $display("FAIL il_rdy2 got=%b exp=10", ifa.req_ready); failures++; end
        cyc();
        set_a(1, 1'b1, 1'b1, 3'd7, 4'hf, 3'd7, 1'b1);
        @(negedge clk);
        checks++; if (ifa.req_ready !== 2'b01) begin $display("FAIL il_rdy3 got=%b exp=01", ifa.req_ready); failures++; end
        cyc();
        set_a(0, 1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0);
        checks++; if (ifa.out_id !== 1'b0) begin $display("FAIL il_id0 got=%b exp=0", ifa.out_id); failures++; end
        checks++; if (ifa.out_sum !== 12'h01f) begin $display("FAIL il_sum0 got=%h exp=01f", ifa.out_sum); failures++; end
        cyc();
        set_a(1, 1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0);
        checks++; if (ifa.out_id !== 1'b1) begin $display("FAIL il_id1 got=%b exp=1", ifa.out_id); failures++; end
        checks++; if (ifa.out_sum !== 12'h03e) begin $display("FAIL il_sum1 got=%h exp=03e", ifa.out_sum); failures++; end
        checks++; if (ifa.out_ovf !== 1'b0) begin $display("FAIL il_ovf1 got=%b exp=0", ifa.out_ovf); failures++; end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_a(1, 1'b1, 1'b0, 3'd7, 4'hf, 3'd7, 1'b1);
        cyc();
        cyc();
        rst = 1'b1;
        set_a(1, 1'b1, 1'b1, 3'd7, 4'h0, 3'd1, 1'b0);
        @(negedge clk);
        checks++; if (ifa.req_ready !== 2'b00) begin $display("FAIL rm_rdy_in_reset got=%b exp=00", ifa.req_ready); failures++; end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ifa.req_ready !== 2'b10) begin $display("FAIL rm_rdy_after got=%b exp=10", ifa.req_ready); failures++; end
        cyc();
        set_a(1, 1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 1'b0);
        checks++; if (ifa.out_valid !== 1'b1) begin $display("FAIL rm_valid got=%b exp=1", ifa.out_valid); failures++; end
        checks++; if (ifa.out_id !== 1'b1) begin $display("FAIL rm_id got=%b exp=1", ifa.out_id); failures++; end
        checks++; if (ifa.out_sum !== 12'h007) begin $display("FAIL rm_sum got=%h exp=007", ifa.out_sum); failures++; end
        checks++; if (ifa.out_ovf !== 1'b0) begin $display("FAIL rm_ovf got=%b exp=0", ifa.out_ovf); failures++; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_backpressure();
        test_overflow();
        test_interleave();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpc1343_share_sched.md
Name: gpc1343_share_sched

Overview:
- Time-shares one combinational gpc1343_5 compressor (columns of 3/4/3/1 bits at weights 1/2/4/8, 5-bit count out) between two requesters that stream multi-beat packets.
- Each requester gets a private accumulator. On a packet's last beat, the block emits the weighted packet total with a requester tag through a single registered output slot.
- It sits between producer lanes of the popcount/compressor datapath and the next reduction stage.

Parameters:
- ACC_W, 12, accumulator and result width in bits; legal range 5..32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  2  per requester (bit i = requester i): beat present.
- req_ready  out  2  per requester: beat accepted this cycle (valid && ready = transfer).
- req_last  in  2  per requester: beat closes the packet.
- req_src0  in  6  requester i uses bits [3i+2:3i]; weight-1 column.
- req_src1  in  8  requester i uses bits [4i+3:4i]; weight-2 column.
- req_src2  in  6  requester i uses bits [3i+2:3i]; weight-4 column.
- req_src3  in  2  requester i uses bit i; weight-8 column.
- out_valid  out  1  result slot full.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- out_id  out  1  requester that produced the result.
- out_sum  out  ACC_W  packet total, modulo 2^ACC_W.
- out_ovf  out  1  accumulation wrapped at least once in this packet.

Behaviour:
- Reset (rst=1 at an edge):
  - acc0 = acc1 = 0; ovf0 = ovf1 = 0.
  - out_valid = 0, out_id = 0, out_sum = 0, out_ovf = 0.
  - Round-robin pointer = 0, so requester 0 has priority first.
  - req_ready is 0 while rst is high.
  - Reset mid-packet discards all partial sums. A beat presented in the reset cycle is not accepted.
- Slot free condition: slot_free = !out_valid || out_ready.
- Eligibility: requester i is eligible when req_valid[i] && (!req_last[i] || slot_free). Non-last beats never wait on the output slot.
- Arbitration:
  - At most one grant per cycle, combinational from the current inputs and state.
  - If both requesters are eligible, the one the pointer names wins.
  - After any grant, the pointer moves to the other requester. With no grant, the pointer holds.
  - req_ready[i] = grant[i]. The grant depends on req_valid and is never asserted for an invalid requester.
- Datapath:
  - A mux selects the granted requester's columns into one gpc1343_5 instance.
  - dst ranges 0..31 and is zero-extended to ACC_W+1 bits; sum = acc[g] + dst.
  - carry = sum[ACC_W]; ovf_next = ovf[g] | carry.
- Non-last beat: acc[g] <= sum[ACC_W-1:0]; ovf[g] <= ovf_next.
- Last beat:
  - out_sum <= sum[ACC_W-1:0], out_ovf <= ovf_next, out_id <= g, out_valid <= 1.
  - acc[g] <= 0, ovf[g] <= 0.
  - Latency: last beat accepted at edge t gives out_valid=1 after edge t, visible in cycle t+1.
  - A single-beat packet (first beat already last) is legal.
- Output slot:
  - out_valid clears on out_valid && out_ready, unless a last beat is accepted in the same cycle; then the slot reloads with the new result, giving back-to-back results with no gap.
  - out_sum, out_id and out_ovf hold stable while out_valid && !out_ready.
- The non-granted requester's accumulator is untouched, so packets from both requesters may interleave beat by beat.
- Empty beats (all columns 0) are legal and add 0.
- X-free: unused mux legs drive 0 into the compressor.

Test Plan:
- Basic sum: req 0 beats (src0=2, src1=a, src2=3, src3=0, last=0) then (src0=0, src1=d, src2=1, src3=1, last=1), out_ready=1 -> beat totals 0x0d then 0x12; out_valid one cycle after the last beat with out_id=0, out_sum=0x1f, out_ovf=0.
- Fairness: both requesters hold valid non-last beats for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with 0 after reset; no starvation.
- Backpressure: out_ready=0 with a result held; req 1 presents a last beat -> req_ready[1]=0 and the slot stays stable. Req 0 non-last beats are still accepted. Raise out_ready -> req 1 is accepted in that same cycle, and the new result appears the next cycle with no gap.
- Overflow: ACC_W=5, req 0 sends two all-ones beats (31 each), the second with last=1 -> out_sum=0x1e, out_ovf=1. The next packet from req 0 reports out_ovf=0.
- Interleave: req 0 packet of beats worth 13+18 and req 1 packet of 31+31, interleaved -> results out_id=0/0x1f and out_id=1/0x3e, each in last-beat order.
- Reset mid-packet: after 2 beats on req 1, assert rst for 1 cycle, then send a single last beat worth 7 -> out_sum=0x07, with the earlier partial sum discarded.
